// File: rtl/graphics_axil_slave_regs.sv
// AXI4-Lite slave register file for the Graphics IP.
// Holds NUM_REGS 32-bit control registers: sprite positions, colours and mode bits.
// The registers drive the pixel logic through a flat bus plus a per-register write strobe.
module graphics_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0]          reg_bus,
  output logic [NUM_REGS-1:0]             reg_wr_strb
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;

  logic [DW-1:0]    regs [NUM_REGS];
  logic             aw_held, w_held, awready, wready, arready;
  logic [IDX_W-1:0] aw_idx;
  logic [DW-1:0]    w_data;
  logic [NB-1:0]    w_strb;
  logic             commit;
  logic [1:0]       bresp;
  logic [IDX_W-1:0] ar_idx;
  logic             ar_hs;
  logic [DW-1:0]    rd_word;
  logic             rd_ok;
  logic [DW-1:0]    rdata;
  logic [1:0]       rresp;

  // Protection bits and the byte offset inside a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == i[IDX_W-1:0]) ok = 1'b1;
    end
    return ok;
  endfunction

  // Write FSM state register.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) w_state <= W_IDLE;
    else              w_state <= w_state_next;
  end

  // Write FSM next state: commit the cycle after both beats are held.
  always_comb begin
    w_state_next = w_state;
    commit       = 1'b0;
    unique case (w_state)
      W_IDLE: if (aw_held && w_held) begin
        commit       = 1'b1;
        w_state_next = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // AW/W capture flags and READYs; each beat is taken independently, cleared on the B handshake.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
    end else if (w_state == W_RESP) begin
      if (S_AXI_BREADY) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        awready <= 1'b1;
        wready  <= 1'b1;
      end
    end else begin
      if (S_AXI_AWVALID && awready) begin
        aw_held <= 1'b1;
        awready <= 1'b0;
      end else if (!aw_held) begin
        awready <= 1'b1;
      end
      if (S_AXI_WVALID && wready) begin
        w_held <= 1'b1;
        wready <= 1'b0;
      end else if (!w_held) begin
        wready <= 1'b1;
      end
    end
  end

  // Captured address/data payload; only meaningful while the matching held flag is set.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_state == W_IDLE && S_AXI_AWVALID && awready) aw_idx <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    if (w_state == W_IDLE && S_AXI_WVALID && wready) begin
      w_data <= S_AXI_WDATA;
      w_strb <= S_AXI_WSTRB;
    end
  end

  // Register update, one-cycle write strobe and write response on commit.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_strb <= '0;
      bresp       <= RESP_OKAY;
    end else begin
      reg_wr_strb <= '0;
      if (commit) begin
        if (idx_ok(aw_idx)) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx == i[IDX_W-1:0]) begin
              reg_wr_strb[i] <= 1'b1;
              for (int b = 0; b < NB; b++) begin
                if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
              end
            end
          end
          bresp <= RESP_OKAY;
        end else begin
          bresp <= RESP_SLVERR;
        end
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) r_state <= R_IDLE;
    else              r_state <= r_state_next;
  end

  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_hs  = (r_state == R_IDLE) && S_AXI_ARVALID && arready;

  // Read FSM next state.
  always_comb begin
    r_state_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_next = R_RESP;
      R_RESP:  if (S_AXI_RREADY) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read mux; sees the pre-commit register value when a write lands on the same edge.
  always_comb begin
    rd_word = '0;
    rd_ok   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == i[IDX_W-1:0]) begin
        rd_word = regs[i];
        rd_ok   = 1'b1;
      end
    end
  end

  // Read data/response registered on the AR handshake and held until RREADY.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      arready <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else if (ar_hs) begin
      arready <= 1'b0;
      rdata   <= rd_ok ? rd_word : '0;
      rresp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_state == R_IDLE || S_AXI_RREADY) begin
      arready <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
    assign reg_bus[32*g +: 32] = regs[g];
  end

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_RVALID  = (r_state == R_RESP);
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

endmodule
